// File: rtl/psg_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : psg_write_ctrl
// Description : Buffers CPU byte writes for an SN76489 PSG in a small FIFO and
//               replays each byte to the chip with a registered nCE/nWE
//               handshake. The handshake waits for READY and gives up after a
//               bounded number of cycles. Overflow and timeout are sticky
//               error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module psg_write_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int READY_TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       nRESET,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [7:0] psg_d,
    output logic       psg_nCE,
    output logic       psg_nWE,
    input  logic       psg_ready,
    output logic       busy,
    output logic [4:0] level,
    output logic       overflow,
    output logic       timeout,
    input  logic       err_clr
);

    localparam int c_ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W  = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(READY_TIMEOUT - 1);
    localparam logic [4:0]         c_FULL      = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_WAIT    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]  r_wrPtr;
    logic [c_ADDR_W-1:0]  r_rdPtr;
    logic [4:0]           r_level;
    logic [c_CNT_W-1:0]   r_waitCnt;
    logic [7:0]           r_psgD;
    logic                 r_psgNce;
    logic                 r_psgNwe;
    logic                 r_overflow;
    logic                 r_timeout;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_overflowSet;
    logic                 w_timeoutSet;

    // Acceptance is judged on the registered occupancy only, so a pop in the
    // same cycle never lets a full FIFO take another byte.
    assign w_full        = (r_level == c_FULL);
    assign w_push        = wr_valid && !w_full;
    assign w_overflowSet = wr_valid && w_full;
    assign w_pop         = (r_state == S_IDLE) && (r_level != 5'd0);

    assign wr_ready = !w_full;
    assign level    = r_level;
    assign busy     = (r_state != S_IDLE) || (r_level != 5'd0);
    assign psg_d    = r_psgD;
    assign psg_nCE  = r_psgNce;
    assign psg_nWE  = r_psgNwe;
    assign overflow = r_overflow;
    assign timeout  = r_timeout;

    // FIFO storage: written on accepted pushes only, no reset needed
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    // FIFO pointers wrap naturally (power-of-two depth); level tracks push/pop
    always_ff @(posedge clock or negedge nRESET) begin
        if (!nRESET) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= 5'd0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Next-state logic for the PSG write handshake
    always_comb begin
        w_nextState  = r_state;
        w_timeoutSet = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != 5'd0) begin
                    w_nextState = S_SETUP;
                end
            end
            S_SETUP:  w_nextState = S_STROBE;
            S_STROBE: w_nextState = S_WAIT;
            S_WAIT: begin
                if (psg_ready) begin
                    w_nextState = S_RELEASE;
                end else if (r_waitCnt == c_WAIT_LAST) begin
                    w_nextState  = S_RELEASE;
                    w_timeoutSet = 1'b1;
                end
            end
            S_RELEASE: w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    // State register plus registered PSG pins decoded from the next state
    always_ff @(posedge clock or negedge nRESET) begin
        if (!nRESET) begin
            r_state  <= S_IDLE;
            r_psgNce <= 1'b1;
            r_psgNwe <= 1'b1;
            r_psgD   <= 8'h00;
        end else begin
            r_state  <= w_nextState;
            r_psgNce <= !((w_nextState == S_SETUP) || (w_nextState == S_STROBE) ||
                          (w_nextState == S_WAIT));
            r_psgNwe <= !((w_nextState == S_STROBE) || (w_nextState == S_WAIT));
            if (w_pop) begin
                r_psgD <= r_mem[r_rdPtr];
            end
        end
    end

    // READY wait counter: cleared on the way into WAIT, counts low-READY cycles
    always_ff @(posedge clock or negedge nRESET) begin
        if (!nRESET) begin
            r_waitCnt <= '0;
        end else if (r_state == S_STROBE) begin
            r_waitCnt <= '0;
        end else if ((r_state == S_WAIT) && !psg_ready && (r_waitCnt != c_WAIT_LAST)) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    // Sticky error flags: a set in the same cycle as a clear wins
    always_ff @(posedge clock or negedge nRESET) begin
        if (!nRESET) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_overflowSet) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_timeoutSet) begin
                r_timeout <= 1'b1;
            end else if (err_clr) begin
                r_timeout <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psg_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_psg_write_ctrl
// Description : Self-checking bench for psg_write_ctrl. A queue-based model
//               predicts FIFO contents, pin levels and flags every cycle;
//               directed scenarios pin the model with literal expectations,
//               then randomized traffic runs against the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psg_write_ctrl;

    localparam int DEPTH = 4;
    localparam int TO    = 64;

    logic       clock = 1'b0;
    logic       nRESET = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic [7:0] psg_d;
    logic       psg_nCE;
    logic       psg_nWE;
    logic       psg_ready = 1'b1;
    logic       busy;
    logic [4:0] level;
    logic       overflow;
    logic       timeout;
    logic       err_clr = 1'b0;

    int nVec = 0;
    int nErr = 0;

    psg_write_ctrl #(
        .FIFO_DEPTH    (DEPTH),
        .READY_TIMEOUT (TO)
    ) dut (
        .clock     (clock),
        .nRESET    (nRESET),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .psg_d     (psg_d),
        .psg_nCE   (psg_nCE),
        .psg_nWE   (psg_nWE),
        .psg_ready (psg_ready),
        .busy      (busy),
        .level     (level),
        .overflow  (overflow),
        .timeout   (timeout),
        .err_clr   (err_clr)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // Phase of the byte being written: 0 none, 1 setup, 2 strobe, 3 waiting
    // for READY, 4 release.
    logic [7:0] mq [$];
    logic [7:0] sbQ [$];
    int         mPhase = 0;
    int         mWaitLow = 0;
    logic [7:0] mD = 8'h00;
    bit         mOvf = 1'b0;
    bit         mTmo = 1'b0;
    int         mOcc;
    bit         mAccept;
    bit         mDrop;
    bit         mTmoSet;
    int         cyc = 0;

    initial forever begin
        @(posedge clock or negedge nRESET);
        if (!nRESET) begin
            mq.delete();
            sbQ.delete();
            mPhase   = 0;
            mWaitLow = 0;
            mD       = 8'h00;
            mOvf     = 1'b0;
            mTmo     = 1'b0;
        end else begin
            cyc     = cyc + 1;
            mOcc    = mq.size();
            mAccept = wr_valid && (mOcc < DEPTH);
            mDrop   = wr_valid && (mOcc >= DEPTH);
            mTmoSet = 1'b0;
            if (mPhase == 0) begin
                if (mOcc > 0) begin
                    mD     = mq.pop_front();
                    mPhase = 1;
                end
            end else if (mPhase == 3) begin
                if (psg_ready) begin
                    mPhase = 4;
                end else if (mWaitLow + 1 >= TO) begin
                    mPhase  = 4;
                    mTmoSet = 1'b1;
                end else begin
                    mWaitLow = mWaitLow + 1;
                end
            end else begin
                mPhase = (mPhase + 1) % 5;
                if (mPhase == 3) mWaitLow = 0;
            end
            if (mAccept) begin
                mq.push_back(wr_data);
                sbQ.push_back(wr_data);
            end
            mOvf = mDrop   ? 1'b1 : (err_clr ? 1'b0 : mOvf);
            mTmo = mTmoSet ? 1'b1 : (err_clr ? 1'b0 : mTmo);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare and strobe monitor ----------------
    bit         prevNwe = 1'b1;
    int         ceRun = 0;
    int         lastCeLow = 0;
    int         peakLvl = 0;
    bit         sawAA = 1'b0;
    int         strobeCyc [$];
    logic [7:0] strobeByte [$];
    logic [7:0] expB;

    initial forever begin
        @(negedge clock);
        check("level",    32'(level),    32'(mq.size()));
        check("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
        check("busy",     32'(busy),     32'((mPhase != 0) || (mq.size() != 0)));
        check("psg_nCE",  32'(psg_nCE),  32'(!((mPhase >= 1) && (mPhase <= 3))));
        check("psg_nWE",  32'(psg_nWE),  32'(!((mPhase == 2) || (mPhase == 3))));
        check("psg_d",    32'(psg_d),    32'(mD));
        check("overflow", 32'(overflow), 32'(mOvf));
        check("timeout",  32'(timeout),  32'(mTmo));
        if (prevNwe && !psg_nWE) begin
            check("strobe_expected", 32'(sbQ.size() > 0), 32'd1);
            if (sbQ.size() > 0) begin
                expB = sbQ.pop_front();
                check("strobe_order", 32'(psg_d), 32'(expB));
            end
            strobeCyc.push_back(cyc);
            strobeByte.push_back(psg_d);
            if (psg_d == 8'hAA) sawAA = 1'b1;
        end
        prevNwe = psg_nWE;
        if (!psg_nCE) begin
            ceRun++;
        end else if (ceRun != 0) begin
            lastCeLow = ceRun;
            ceRun     = 0;
        end
        if (int'(level) > peakLvl) peakLvl = int'(level);
    end

    // ---------------- stimulus helpers ----------------
    task automatic pushByte(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        @(negedge clock);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic waitIdle(input int maxCyc);
        int n = 0;
        while (busy && n < maxCyc) begin
            @(negedge clock);
            n++;
        end
        #1;
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int ceCnt;
        int weCnt;
        int idx0;
        int n0;
        int mode;

        #1 nRESET = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_nCE",      32'(psg_nCE),  32'd1);
        check("rst_nWE",      32'(psg_nWE),  32'd1);
        check("rst_d",        32'(psg_d),    32'h00);
        check("rst_level",    32'(level),    32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_timeout",  32'(timeout),  32'd0);
        nRESET = 1'b1;
        @(negedge clock);
        #1;

        // single byte with READY high: 5-cycle byte
        psg_ready = 1'b1;
        pushByte(8'h9F);
        ceCnt = 0;
        weCnt = 0;
        for (int i = 2; i <= 6; i++) begin
            @(negedge clock);
            #1;
            if (!psg_nCE) ceCnt++;
            if (!psg_nWE) weCnt++;
            if (i == 2) begin
                check("single_d",     32'(psg_d),   32'h9F);
                check("single_setup", 32'(psg_nCE), 32'd0);
            end
        end
        check("single_ce_cycles", 32'(ceCnt), 32'd3);
        check("single_we_cycles", 32'(weCnt), 32'd2);
        check("single_busy_e6",   32'(busy),  32'd0);

        // four bytes back to back
        peakLvl = 0;
        idx0    = strobeCyc.size();
        pushByte(8'h80);
        pushByte(8'h05);
        pushByte(8'h90);
        pushByte(8'hBF);
        waitIdle(100);
        check("b2b_count", 32'(strobeCyc.size() - idx0), 32'd4);
        if (strobeCyc.size() - idx0 == 4) begin
            for (int k = 1; k < 4; k++) begin
                check("b2b_spacing", 32'(strobeCyc[idx0+k] - strobeCyc[idx0+k-1]), 32'd5);
            end
            check("b2b_byte0", 32'(strobeByte[idx0]),   32'h80);
            check("b2b_byte1", 32'(strobeByte[idx0+1]), 32'h05);
            check("b2b_byte2", 32'(strobeByte[idx0+2]), 32'h90);
            check("b2b_byte3", 32'(strobeByte[idx0+3]), 32'hBF);
        end
        check("b2b_peak", 32'(peakLvl), 32'd3);

        // overflow: fill with READY low, then offer 0xAA
        sawAA     = 1'b0;
        psg_ready = 1'b0;
        pushByte(8'h11);
        pushByte(8'h22);
        pushByte(8'h33);
        pushByte(8'h44);
        pushByte(8'h55);
        check("ovf_full_level", 32'(level),    32'd4);
        check("ovf_wr_ready",   32'(wr_ready), 32'd0);
        pushByte(8'hAA);
        check("ovf_flag",       32'(overflow), 32'd1);
        check("ovf_level_kept", 32'(level),    32'd4);
        psg_ready = 1'b1;
        waitIdle(200);
        check("ovf_no_AA", 32'(sawAA), 32'd0);
        err_clr = 1'b1;
        @(negedge clock);
        #1;
        err_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // READY low for 32 WAIT cycles then high
        psg_ready = 1'b0;
        pushByte(8'h42);
        repeat (35) @(negedge clock);
        #1;
        psg_ready = 1'b1;
        waitIdle(100);
        check("ready32_ce_cycles", 32'(lastCeLow), 32'd35);
        check("ready32_timeout",   32'(timeout),   32'd0);

        // READY low forever: abort after TO WAIT cycles
        psg_ready = 1'b0;
        pushByte(8'h43);
        waitIdle(200);
        check("tmo_ce_cycles", 32'(lastCeLow), 32'(TO + 2));
        check("tmo_flag",      32'(timeout),   32'd1);
        err_clr = 1'b1;
        @(negedge clock);
        #1;
        err_clr   = 1'b0;
        psg_ready = 1'b1;
        check("tmo_clr", 32'(timeout), 32'd0);

        // reset in the middle of WAIT
        psg_ready = 1'b0;
        pushByte(8'hA1);
        pushByte(8'hB2);
        repeat (2) @(negedge clock);
        #1;
        check("mid_pre_nWE",   32'(psg_nWE), 32'd0);
        check("mid_pre_level", 32'(level),   32'd1);
        #1 nRESET = 1'b0;
        #1;
        check("mid_rst_nCE",   32'(psg_nCE), 32'd1);
        check("mid_rst_nWE",   32'(psg_nWE), 32'd1);
        check("mid_rst_level", 32'(level),   32'd0);
        @(negedge clock);
        #1;
        nRESET    = 1'b1;
        psg_ready = 1'b1;
        n0 = strobeByte.size();
        repeat (3) @(negedge clock);
        #1;
        check("post_rst_idle", 32'(busy), 32'd0);
        pushByte(8'h5A);
        waitIdle(100);
        check("post_rst_strobes", 32'(strobeByte.size() - n0), 32'd1);
        if (strobeByte.size() > 0) begin
            check("post_rst_byte", 32'(strobeByte[strobeByte.size()-1]), 32'h5A);
        end

        // randomized traffic against the model
        for (int blk = 0; blk < 16; blk++) begin
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 100; c++) begin
                wr_valid  = ($urandom_range(0, 2) != 0);
                wr_data   = 8'($urandom);
                psg_ready = (mode == 0) ? 1'b1 :
                            (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
                err_clr   = ($urandom_range(0, 39) == 0);
                nRESET    = ($urandom_range(0, 299) != 0);
                @(negedge clock);
                #1;
            end
        end
        wr_valid  = 1'b0;
        err_clr   = 1'b0;
        nRESET    = 1'b1;
        psg_ready = 1'b1;
        waitIdle(300);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
